// File: rtl/uart_reg_cmd_ctrl.sv
// Purpose : parses SYNC/ADDR/DATA/CHK write frames from a uart byte stream and commits
//           DATA into one of NREGS output registers; aborts and counts bad or stalled frames.
// Latency : CHK byte accepted at edge N -> register and wr_strobe update at edge N+1.
// Backpr. : none; every rx_valid byte is consumed in the cycle it arrives.
//
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   rx_valid/rx_data     one-cycle byte strobe and byte from the uart receiver
//   rx_break             uart BREAK indication (level or pulse)
//   regs                 register bank, reg[i] = regs[i*WORDSZ +: WORDSZ]
//   wr_strobe            one-cycle pulse per commit
//   wr_addr              address of the last commit (held)
//   err_cnt              saturating count of aborted frames
//   state                FSM state code for debug/LEDs
module uart_reg_cmd_ctrl #(
    parameter int                WORDSZ      = 8,
    parameter int                NREGS       = 4,
    parameter logic [WORDSZ-1:0] SYNC        = 8'hA5,
    parameter int                TIMEOUT_CYC = 1_000_000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rx_valid,
    input  logic [WORDSZ-1:0]       rx_data,
    input  logic                    rx_break,
    output logic [NREGS*WORDSZ-1:0] regs,
    output logic                    wr_strobe,
    output logic [WORDSZ-1:0]       wr_addr,
    output logic [7:0]              err_cnt,
    output logic [3:0]              state
);

    localparam int                TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]     TMAX    = TW'(TIMEOUT_CYC - 1);
    // One bit wider than an address so NREGS == 2**WORDSZ is representable.
    localparam logic [WORDSZ:0]   NREGS_W = (WORDSZ + 1)'(NREGS);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GET_ADDR = 4'd1,
        S_GET_DATA = 4'd2,
        S_GET_CHK  = 4'd3,
        S_COMMIT   = 4'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [WORDSZ-1:0]         addr_q, addr_d;
    logic [WORDSZ-1:0]         data_q, data_d;
    logic [TW-1:0]             timer_q, timer_d;
    logic [NREGS*WORDSZ-1:0]   regs_q, regs_d;
    logic                      wr_strobe_q;
    logic [WORDSZ-1:0]         wr_addr_q, wr_addr_d;
    logic [7:0]                err_cnt_q, err_cnt_d;

    logic in_get;
    logic timed_out;
    logic chk_ok;
    logic addr_ok;
    logic err;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err       = 1'b0;
        in_get    = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA) ||
                    (state_q == S_GET_CHK);
        timed_out = in_get && (timer_q == TMAX);
        chk_ok    = (rx_data == (SYNC ^ addr_q ^ data_q));
        addr_ok   = ({1'b0, addr_q} < NREGS_W);

        // Break beats timeout beats a byte arriving in the same cycle.
        if (in_get && (rx_break || timed_out)) begin
            err     = 1'b1;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                // COMMIT lasts one cycle and behaves like IDLE towards the byte stream,
                // so a SYNC arriving right after a CHK byte is not lost.
                S_IDLE, S_COMMIT: begin
                    if (rx_valid && !rx_break && (rx_data == SYNC)) begin
                        state_d = S_GET_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_GET_ADDR: begin
                    if (rx_valid) begin
                        addr_d  = rx_data;
                        state_d = S_GET_DATA;
                    end
                end
                S_GET_DATA: begin
                    if (rx_valid) begin
                        data_d  = rx_data;
                        state_d = S_GET_CHK;
                    end
                end
                S_GET_CHK: begin
                    if (rx_valid) begin
                        if (chk_ok && addr_ok) begin
                            state_d = S_COMMIT;
                        end else begin
                            err     = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Timer only runs while waiting inside a frame; any byte restarts it.
        if (in_get && !rx_valid && (state_d != S_IDLE)) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = '0;
        end
    end

    always_comb begin
        regs_d    = regs_q;
        wr_addr_d = wr_addr_q;
        if (state_q == S_COMMIT) begin
            wr_addr_d = addr_q;
            for (int i = 0; i < NREGS; i++) begin
                if ({1'b0, addr_q} == (WORDSZ + 1)'(i)) begin
                    regs_d[i*WORDSZ +: WORDSZ] = data_q;
                end
            end
        end
        err_cnt_d = err_cnt_q;
        if (err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            timer_q     <= '0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            timer_q     <= timer_d;
            regs_q      <= regs_d;
            wr_strobe_q <= (state_q == S_COMMIT);
            wr_addr_q   <= wr_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign regs      = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign err_cnt   = err_cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_uart_reg_cmd_ctrl.sv
// Purpose : directed self-checking bench for uart_reg_cmd_ctrl.
// Latency : inputs driven on falling edges, outputs sampled on falling edges.
// Backpr. : not applicable.
module tb_uart_reg_cmd_ctrl;

    localparam int TOUT = 40;
    localparam logic [7:0] SY = 8'hA5;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_break = 1'b0;
    logic [31:0] regs;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic [7:0]  err_cnt;
    logic [3:0]  state;

    uart_reg_cmd_ctrl #(
        .WORDSZ(8), .NREGS(4), .SYNC(8'hA5), .TIMEOUT_CYC(TOUT)
    ) dut (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .err_cnt(err_cnt), .state(state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] regs_m;
    logic [7:0]  waddr_m;
    logic [7:0]  err_m;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] chk;
        bit         commit;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called on a falling edge; the byte is sampled by the next rising edge.
    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(SY);
        send(a);
        send(d);
        send(c);
    endtask

    task automatic err_inc();
        if (err_m != 8'hFF) err_m = err_m + 8'd1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " regs"},    regs,           regs_m);
        check({tag, " err_cnt"}, {24'd0, err_cnt}, {24'd0, err_m});
        check({tag, " wr_addr"}, {24'd0, wr_addr}, {24'd0, waddr_m});
    endtask

    // After a CHK byte: COMMIT state, then strobe + register update, then strobe low.
    task automatic expect_commit(input string tag, input logic [7:0] a, input logic [7:0] d);
        check({tag, " state commit"}, {28'd0, state}, 32'd4);
        @(negedge clk);
        regs_m[a*8 +: 8] = d;
        waddr_m = a;
        check({tag, " strobe hi"}, {31'd0, wr_strobe}, 32'd1);
        check_outputs(tag);
        @(negedge clk);
        check({tag, " strobe lo"}, {31'd0, wr_strobe}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{addr: 8'h01, data: 8'h3C, chk: 8'h98, commit: 1'b1};
        vecs[1] = '{addr: 8'h02, data: 8'h55, chk: 8'h00, commit: 1'b0};
        vecs[2] = '{addr: 8'h07, data: 8'h11, chk: 8'hB3, commit: 1'b0};
        vecs[3] = '{addr: 8'h00, data: 8'hA5, chk: 8'h00, commit: 1'b1};
        vecs[4] = '{addr: 8'h03, data: 8'h7E, chk: 8'hD8, commit: 1'b1};
        vecs[5] = '{addr: 8'h02, data: 8'hC3, chk: 8'h64, commit: 1'b1};
        vecs[6] = '{addr: 8'h04, data: 8'h00, chk: 8'hA1, commit: 1'b0};
        vecs[7] = '{addr: 8'h03, data: 8'hFF, chk: 8'h58, commit: 1'b0};

        regs_m = '0; waddr_m = '0; err_m = '0;

        // Reset state
        #12;
        check("reset regs", regs, 32'd0);
        check("reset state", {28'd0, state}, 32'd0);
        check("reset strobe", {31'd0, wr_strobe}, 32'd0);
        check_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Table of whole frames
        for (int i = 0; i < 8; i++) begin
            frame(vecs[i].addr, vecs[i].data, vecs[i].chk);
            if (vecs[i].commit) begin
                expect_commit($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
            end else begin
                err_inc();
                check($sformatf("vec%0d state", i), {28'd0, state}, 32'd0);
                @(negedge clk);
                check($sformatf("vec%0d strobe", i), {31'd0, wr_strobe}, 32'd0);
                check_outputs($sformatf("vec%0d", i));
            end
        end

        // Inter-byte timeout: last byte then TOUT idle cycles
        send(SY);
        send(8'h01);
        repeat (TOUT - 1) @(negedge clk);
        check("tout before", {28'd0, state}, 32'd2);
        @(negedge clk);
        err_inc();
        check("tout state", {28'd0, state}, 32'd0);
        check_outputs("tout");
        frame(8'h01, 8'h77, 8'hD3);
        expect_commit("after tout", 8'h01, 8'h77);

        // Gaps just short of the timeout restart the timer on each byte
        send(SY);
        repeat (TOUT - 2) @(negedge clk);
        send(8'h01);
        repeat (TOUT - 2) @(negedge clk);
        send(8'h66);
        repeat (TOUT - 2) @(negedge clk);
        send(8'hC2);
        expect_commit("slow frame", 8'h01, 8'h66);

        // Break with a simultaneous byte aborts the frame
        send(SY);
        send(8'h03);
        rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
        @(negedge clk);
        rx_break = 1'b0; rx_valid = 1'b0;
        err_inc();
        check("break state", {28'd0, state}, 32'd0);
        @(negedge clk);
        check("break strobe", {31'd0, wr_strobe}, 32'd0);
        check_outputs("break");

        // Break while idle is not an error
        rx_break = 1'b1;
        @(negedge clk);
        rx_break = 1'b0;
        check("idle break state", {28'd0, state}, 32'd0);
        check_outputs("idle break");

        // Break during COMMIT does not stop the commit
        frame(8'h02, 8'hD9, 8'h7E);
        check("cbrk state", {28'd0, state}, 32'd4);
        rx_break = 1'b1;
        @(negedge clk);
        rx_break = 1'b0;
        regs_m[16 +: 8] = 8'hD9;
        waddr_m = 8'h02;
        check("cbrk strobe", {31'd0, wr_strobe}, 32'd1);
        check_outputs("cbrk");

        // SYNC arriving during COMMIT starts the next frame
        frame(8'h00, 8'h12, 8'hB7);
        check("b2b state commit", {28'd0, state}, 32'd4);
        send(SY);
        check("b2b state addr", {28'd0, state}, 32'd1);
        check("b2b reg0", regs, {regs_m[31:8], 8'h12});
        regs_m[7:0] = 8'h12;
        send(8'h02);
        send(8'h11);
        send(8'hB6);
        expect_commit("b2b second", 8'h02, 8'h11);

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            frame(8'h00, 8'h00, 8'h00);
            err_inc();
        end
        @(negedge clk);
        check("sat err_cnt", {24'd0, err_cnt}, 32'h0000_00FF);
        check_outputs("sat");

        // Asynchronous reset mid-frame
        send(SY);
        send(8'h02);
        #3 resetn = 1'b0;
        #1;
        check("arst regs", regs, 32'd0);
        check("arst state", {28'd0, state}, 32'd0);
        check("arst err", {24'd0, err_cnt}, 32'd0);
        check("arst waddr", {24'd0, wr_addr}, 32'd0);
        check("arst strobe", {31'd0, wr_strobe}, 32'd0);
        regs_m = '0; waddr_m = '0; err_m = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        frame(8'h00, 8'hFF, 8'h5A);
        expect_commit("post reset", 8'h00, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
